// File: rtl/puf_challenge_sequencer.sv
// Splits a latched challenge word into NUM_CHAL sub-challenges, runs each through the
// PUF (reset, evaluate, capture) and publishes the packed responses with an XOR-fold bit.
module puf_challenge_sequencer #(
  parameter int unsigned CHAL_WIDTH  = 32,
  parameter int unsigned NUM_CHAL    = 4,
  parameter int unsigned RESP_WIDTH  = 4,
  parameter int unsigned WAIT_CYCLES = 15,
  parameter int unsigned CNT_WIDTH   = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             trigger,
  input  logic                             abort,
  input  logic [CHAL_WIDTH*NUM_CHAL-1:0]   dataIn,
  input  logic [RESP_WIDTH-1:0]            pufResponse,
  output logic [CHAL_WIDTH-1:0]            challenge,
  output logic                             pufStart,
  output logic                             pufReset,
  output logic                             busy,
  output logic                             done,
  output logic [RESP_WIDTH*NUM_CHAL-1:0]   dataOut,
  output logic                             xorOut
);

  localparam int unsigned IN_WIDTH  = CHAL_WIDTH * NUM_CHAL;
  localparam int unsigned OUT_WIDTH = RESP_WIDTH * NUM_CHAL;
  localparam int unsigned IDX_W     = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESET  = 3'd1,
    EVAL    = 3'd2,
    CAPTURE = 3'd3,
    FINISH  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [IN_WIDTH-1:0]    buf_q, buf_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   shadow_q, shadow_d;
  logic [CHAL_WIDTH-1:0]  challenge_q, challenge_d;
  logic                   pufstart_q, pufstart_d;
  logic                   pufreset_q, pufreset_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [OUT_WIDTH-1:0]   dataout_q, dataout_d;
  logic                   xorout_q, xorout_d;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      challenge_q <= '0;
      pufstart_q  <= 1'b0;
      pufreset_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dataout_q   <= '0;
      xorout_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      challenge_q <= challenge_d;
      pufstart_q  <= pufstart_d;
      pufreset_q  <= pufreset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dataout_q   <= dataout_d;
      xorout_q    <= xorout_d;
    end
  end

  // Next-state logic; PUF controls are derived from the next state so they line up with it
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    challenge_d = challenge_q;
    dataout_d   = dataout_q;
    xorout_d    = xorout_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger && !abort) begin
          buf_d   = dataIn;
          idx_d   = '0;
          state_d = PRESET;
        end
      end
      PRESET: begin
        cnt_d   = '0;
        state_d = EVAL;
      end
      EVAL: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(WAIT_CYCLES - 1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        for (int i = 0; i < int'(NUM_CHAL); i++) begin
          if (idx_q == IDX_W'(i)) begin
            shadow_d[i*RESP_WIDTH +: RESP_WIDTH] = pufResponse;
          end
        end
        if (idx_q == IDX_W'(NUM_CHAL - 1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = PRESET;
        end
      end
      FINISH: begin
        dataout_d = shadow_q;
        xorout_d  = ^shadow_q;
        done_d    = 1'b1;
        idx_d     = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A cancelled run publishes nothing and forgets its partial responses
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      idx_d     = '0;
      shadow_d  = '0;
      done_d    = 1'b0;
      dataout_d = dataout_q;
      xorout_d  = xorout_q;
    end

    if (state_d == PRESET) begin
      for (int i = 0; i < int'(NUM_CHAL); i++) begin
        if (idx_d == IDX_W'(i)) begin
          challenge_d = buf_d[i*CHAL_WIDTH +: CHAL_WIDTH];
        end
      end
    end

    pufstart_d = (state_d == EVAL);
    pufreset_d = (state_d != EVAL);
    busy_d     = (state_d == PRESET) || (state_d == EVAL) || (state_d == CAPTURE);
  end

  assign challenge = challenge_q;
  assign pufStart  = pufstart_q;
  assign pufReset  = pufreset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dataOut   = dataout_q;
  assign xorOut    = xorout_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: run-level model checked every cycle plus directed scenarios.
module tb_puf_challenge_sequencer;

  localparam int CW   = 32;
  localparam int NC   = 4;
  localparam int RW   = 4;
  localparam int WC   = 15;
  localparam int SUB  = WC + 2;
  localparam int RUN  = NC * SUB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            trigger, abort;
  logic [127:0]    dataIn;
  logic [3:0]      pufResponse;
  logic [31:0]     challenge;
  logic            pufStart, pufReset, busy, done;
  logic [15:0]     dataOut;
  logic            xorOut;

  logic            trig2;
  logic [127:0]    dataIn2;
  logic [7:0]      resp2;
  logic [63:0]     chal2;
  logic            start2, prst2, busy2, done2;
  logic [15:0]     dataOut2;
  logic            xor2;

  assign pufResponse = challenge[3:0] ^ 4'h5;
  assign resp2       = chal2[7:0] ^ 8'hA5;

  puf_challenge_sequencer dut (
    .clk(clk), .reset(reset), .trigger(trigger), .abort(abort), .dataIn(dataIn),
    .pufResponse(pufResponse), .challenge(challenge), .pufStart(pufStart),
    .pufReset(pufReset), .busy(busy), .done(done), .dataOut(dataOut), .xorOut(xorOut)
  );

  puf_challenge_sequencer #(
    .CHAL_WIDTH(64), .NUM_CHAL(2), .RESP_WIDTH(8), .WAIT_CYCLES(3), .CNT_WIDTH(5)
  ) dut2 (
    .clk(clk), .reset(reset), .trigger(trig2), .abort(1'b0), .dataIn(dataIn2),
    .pufResponse(resp2), .challenge(chal2), .pufStart(start2),
    .pufReset(prst2), .busy(busy2), .done(done2), .dataOut(dataOut2), .xorOut(xor2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Run-level model: a run is a window of RUN cycles after acceptance, done RUN+1 cycles later
  function automatic logic [15:0] expect_resp(input logic [127:0] d);
    logic [15:0] r;
    for (int i = 0; i < NC; i++) r[i*RW +: RW] = d[i*CW +: 4] ^ 4'h5;
    return r;
  endfunction

  bit          m_active;
  int          m_k;
  logic [127:0] m_buf;
  logic [15:0] m_result, m_data;
  logic [31:0] m_chal;
  logic        m_xor, m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_k = 0; m_buf = '0; m_result = '0;
      m_data = '0; m_xor = 0; m_done = 0; m_chal = '0;
    end else begin
      m_done = 0;
      if (m_active) begin
        if (abort) m_active = 0;
        else begin
          m_k++;
          if (m_k == RUN + 1) begin
            m_active = 0; m_done = 1; m_data = m_result; m_xor = ^m_result;
          end
        end
      end else if (trigger && !abort) begin
        m_active = 1; m_k = 0; m_buf = dataIn; m_result = expect_resp(dataIn);
      end
      if (m_active && m_k < RUN) m_chal = m_buf[(m_k / SUB) * CW +: CW];
    end
  end

  always @(negedge clk) begin
    bit in_run, e_start;
    in_run  = m_active && (m_k < RUN);
    e_start = in_run && ((m_k % SUB) >= 1) && ((m_k % SUB) <= WC);
    check("challenge", challenge, m_chal);
    check("pufStart",  pufStart,  e_start);
    check("pufReset",  pufReset,  !e_start);
    check("busy",      busy,      in_run);
    check("done",      done,      m_done);
    check("dataOut",   dataOut,   m_data);
    check("xorOut",    xorOut,    m_xor);
  end

  // Activity monitor for the directed checks
  int done_cnt, done_cyc, busy_cnt, rst_lo_cnt, run_len;
  int runs[$];
  logic [31:0] chal_seq[$];
  int done2_cnt = 0, done2_cyc = 0;

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (!pufReset) rst_lo_cnt++;
    if (pufStart) begin
      if (run_len == 0) chal_seq.push_back(challenge);
      run_len++;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
  end

  task automatic clear_mon();
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; rst_lo_cnt = 0; run_len = 0;
    runs.delete(); chal_seq.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(output int t0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, input int target);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    if (done_cnt < target) check("done_timeout", 128'(done_cnt), 128'(target));
  endtask

  int t0, first;

  initial begin
    reset = 1'b1; trigger = 1'b0; abort = 1'b0; dataIn = '0;
    trig2 = 1'b0; dataIn2 = '0;
    clear_mon();
    tick(); tick();
    check("rst_pufReset", pufReset, 1'b1);
    check("rst_dataOut", dataOut, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_challenge", challenge, 32'h0);
    reset = 1'b0;
    tick();

    // Basic run with phase accounting
    clear_mon();
    dataIn = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse(t0);
    dataIn = '1;
    wait_done(100, 1);
    check("latency", 128'(done_cyc - t0), 128'(69));
    check("run1_dataOut", dataOut, 16'h1674);
    check("run1_xorOut", xorOut, 1'b1);
    check("run1_busy_cycles", 128'(busy_cnt), 128'(68));
    check("run1_reset_low_cycles", 128'(rst_lo_cnt), 128'(60));
    check("run1_start_runs", 128'(runs.size()), 128'(4));
    for (int i = 0; i < runs.size(); i++) check("run1_start_len", 128'(runs[i]), 128'(15));
    check("run1_chal_count", 128'(chal_seq.size()), 128'(4));
    for (int i = 0; i < chal_seq.size(); i++) check("run1_chal_seq", chal_seq[i], 128'(i + 1));
    repeat (3) tick();
    check("run1_single_done", 128'(done_cnt), 128'(1));

    // Abort during the second sub-challenge's evaluate phase
    clear_mon();
    dataIn = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse(t0);
    while (cyc < t0 + 20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_pufStart", pufStart, 1'b0);
    check("abort_pufReset", pufReset, 1'b1);
    repeat (80) tick();
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_keeps_data", dataOut, 16'h1674);

    // Abort and trigger together in IDLE start nothing
    abort = 1'b1; trigger = 1'b1;
    tick();
    abort = 1'b0; trigger = 1'b0;
    tick();
    check("abort_trig_idle", busy, 1'b0);

    // Fresh run after the abort
    clear_mon();
    dataIn = {32'h8, 32'h7, 32'h6, 32'h5};
    pulse(t0);
    wait_done(100, 1);
    check("run2_latency", 128'(done_cyc - t0), 128'(69));
    check("run2_dataOut", dataOut, 16'hD230);
    check("run2_xorOut", xorOut, 1'b0);

    // Trigger held high: back-to-back runs
    repeat (2) tick();
    clear_mon();
    dataIn = '0;
    trigger = 1'b1;
    wait_done(100, 1);
    first = done_cyc;
    wait_done(100, 2);
    trigger = 1'b0;
    check("b2b_spacing", 128'(done_cyc - first), 128'(70));
    check("b2b_dataOut", dataOut, 16'h5555);
    check("b2b_xorOut", xorOut, 1'b0);
    repeat (3) tick();

    // Asynchronous reset mid-evaluate
    clear_mon();
    dataIn = {32'h4, 32'h3, 32'h2, 32'h1};
    pulse(t0);
    while (cyc < t0 + 5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("areset_pufReset", pufReset, 1'b1);
    check("areset_dataOut", dataOut, 16'h0);
    check("areset_busy", busy, 1'b0);
    check("areset_pufStart", pufStart, 1'b0);
    tick();
    reset = 1'b0;
    repeat (100) tick();
    check("areset_no_done", 128'(done_cnt), 128'(0));

    // Narrow configuration: two 64-bit sub-challenges, 8-bit responses, 3-cycle evaluate
    dataIn2 = {64'h22, 64'h11};
    trig2 = 1'b1;
    tick();
    trig2 = 1'b0;
    t0 = cyc;
    begin
      int n = 0;
      while (done2_cnt == 0 && n < 50) begin tick(); n++; end
    end
    check("sweep_done_seen", 128'(done2_cnt), 128'(1));
    check("sweep_latency", 128'(done2_cyc - t0), 128'(11));
    check("sweep_dataOut", dataOut2, 16'h87B4);
    check("sweep_xorOut", xor2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
